i2s_adc_rx: RTL and testbench
=============================

// Module: i2s_adc_rx
// PURPOSE
//  Receives 24-bit stereo I2S capture data from the codec ADC (i2s_adcdat), framed by the fabric-generated
//  i2s_bclk/i2s_lrclk. Deserializes each slot, pairs left+right words, buffers pairs in a small FIFO,
//  and presents them on a valid/ready stream for downstream DSP/UART logic. Sits beside the clock/I2C setup logic.
// PARAMETERS
//  DATA_W      24  bits per channel; slot length in bclk periods equals DATA_W
//  FIFO_DEPTH  4   stereo pairs buffered; power of 2, >=2
// PORTS
//  clk           in   1       system clock (73.728 MHz); the only clock
//  rst           in   1       synchronous, active-high reset
//  i2s_bclk      in   1       bit clock (clk/32), sampled as data, not used as a clock
//  i2s_lrclk     in   1       word select; 0=left, 1=right
//  i2s_adcdat    in   1       serial ADC data, MSB first, changes on bclk fall
//  out_left      out  DATA_W  left sample, two's complement
//  out_right     out  DATA_W  right sample, two's complement
//  out_valid     out  1       pair available
//  out_ready     in   1       consumer accepts pair when out_valid&&out_ready
//  overflow      out  1       sticky: pair dropped because FIFO full
//  overflow_clr  in   1       clears overflow
//  sync_err      out  1       1-clk pulse: slot length != DATA_W bclk
// BEHAVIOUR
//  - Inputs pass through a 2-flop synchronizer; all three share identical delay, so alignment is preserved.
//  - bclk rise = synced bclk 1 && previous 0; all capture happens only on that cycle.
//  - I2S 1-bit delay: at the first rise where lrclk differs from lr_prev, adcdat is the previous word's LSB.
//    At that rise: word = {shreg[DATA_W-2:0], adcdat}; valid iff bit_cnt == DATA_W-1; bit_cnt<=0; lr_prev<=lrclk.
//    Other rises: shreg shifts in adcdat; bit_cnt increments, saturating at DATA_W.
//  - FSM: WAIT_SYNC (reset) -> CAPTURE on the first lrclk change; that first word is always discarded.
//    CAPTURE: completed left word (lr_prev=0) -> held, left_ok=1. Completed right word -> if left_ok,
//    push {left,right} and clear left_ok; else drop.
//    bit_cnt mismatch: sync_err pulses, word dropped, left_ok<=0, remain in CAPTURE.
//  - Push with FIFO full: pair dropped, overflow<=1. Push and pop in the same clk with FIFO full: pop first, push accepted.
//  - overflow_clr and a new overflow in the same clk: overflow stays 1.
//  - Latency: out_valid rises 4 clk after the clk edge where i2s_bclk is first sampled high for the completing rise (FIFO empty).
//  - out_left/out_right hold the FIFO head; stable while out_valid && !out_ready.
//  - Reset (anytime, incl. mid-slot): FIFO emptied, state WAIT_SYNC, shreg/bit_cnt/left_ok=0.
//    Outputs: out_valid=0, out_left=out_right=0, overflow=0, sync_err=0; peak_l=peak_r=0 when enabled.
// CONFIGURATION
//  I2S_RX_PEAK_EN defined: adds ports peak_l/peak_r out DATA_W-1 (max |sample| per channel) and peak_clr in 1.
//   Peaks update on each FIFO push. |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1.
//   peak_clr zeroes both peaks; a push in the same clk loads that pair's magnitudes.
//  Not defined: ports and peak logic absent; all other behaviour identical.
// STRUCTURE
//  i2s_pkg: I2S_DATA_W=24, rx state enum {WAIT_SYNC, CAPTURE}, CH_LEFT=0/CH_RIGHT=1 constants.
//  Sub-module i2s_rx_fifo: sync FIFO, width 2*DATA_W, depth FIFO_DEPTH, show-ahead head, full/empty flags.
// TESTING
//  1 Reset, then frames L=24'hABCDEF R=24'h123456 -> first pair dropped; next pairs out_left=ABCDEF, out_right=123456.
//  2 out_ready=0 for 6 frames -> 4 pairs held, overflow=1. Drain -> pairs 1..4 in order. overflow_clr -> overflow=0.
//  3 Left slot of 20 bclk -> one sync_err pulse; no pair that frame; next full frame emits normally.
//  4 rst asserted at bit 10 of a right slot -> out_valid=0 next clk; first frame after release dropped; then correct.
//  5 L=24'h800000, R=24'h7FFFFF, ready=1 -> exact values, out_valid 4 clk after completing bclk rise, no backpressure stalls.
//  6 [I2S_RX_PEAK_EN] L=-5,R=3 then L=2,R=-9 -> peak_l=5, peak_r=9. peak_clr -> 0. L=24'h800000 -> peak_l=7FFFFF.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S capture receiver.
package i2s_pkg;

   localparam int I2S_DATA_W = 24;

   typedef enum logic [0:0] {
      WAIT_SYNC = 1'b0,
      CAPTURE   = 1'b1
   } rx_state_t;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous FIFO with show-ahead head; the head reads as zero while empty.
module i2s_rx_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_rd;
   logic             do_wr;

   assign full  = (count_reg == FULL_CNT);
   assign empty = (count_reg == '0);
   // A read frees a slot in the same cycle, so a write into a full FIFO is accepted alongside it.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);
   assign head  = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_rd) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count_reg <= count_reg + (AW + 1)'(1);
            2'b01:   count_reg <= count_reg - (AW + 1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S stereo capture: oversampled bclk/lrclk/adcdat -> paired words -> FIFO -> valid/ready stream.
// Define I2S_RX_PEAK_EN to add per-channel peak magnitude meters (peak_l/peak_r/peak_clr).
module i2s_adc_rx
   import i2s_pkg::*;
#(
   parameter int DATA_W     = I2S_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i2s_bclk,
   input  logic              i2s_lrclk,
   input  logic              i2s_adcdat,
   output logic [DATA_W-1:0] out_left,
   output logic [DATA_W-1:0] out_right,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   input  logic              overflow_clr,
   output logic              sync_err
`ifdef I2S_RX_PEAK_EN
   ,
   output logic [DATA_W-2:0] peak_l,
   output logic [DATA_W-2:0] peak_r,
   input  logic              peak_clr
`endif
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_W);

   logic [1:0]        bclk_sync_reg;
   logic [1:0]        lr_sync_reg;
   logic [1:0]        dat_sync_reg;
   logic              bclk_prev_reg;
   logic              bclk_rise;
   logic              lr_s;
   logic              dat_s;

   logic [DATA_W-2:0] shreg_reg;
   logic [CW-1:0]     bit_cnt_reg;
   logic              lr_prev_reg;
   logic [DATA_W-1:0] word_reg;
   logic              word_done_reg;
   logic              word_good_reg;
   logic              word_ch_reg;

   rx_state_t           state_reg;
   logic [DATA_W-1:0]   left_hold_reg;
   logic                left_ok_reg;
   logic                push_reg;
   logic [2*DATA_W-1:0] push_data_reg;
   logic                sync_err_reg;
   logic                overflow_reg;

   logic                fifo_full;
   logic                fifo_empty;
   logic                pop;
   logic [2*DATA_W-1:0] fifo_head;

   // All three inputs share the same two-stage path so their relative alignment is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         bclk_sync_reg <= '0;
         lr_sync_reg   <= '0;
         dat_sync_reg  <= '0;
         bclk_prev_reg <= 1'b0;
      end else begin
         bclk_sync_reg <= {bclk_sync_reg[0], i2s_bclk};
         lr_sync_reg   <= {lr_sync_reg[0], i2s_lrclk};
         dat_sync_reg  <= {dat_sync_reg[0], i2s_adcdat};
         bclk_prev_reg <= bclk_sync_reg[1];
      end
   end

   assign bclk_rise = bclk_sync_reg[1] && !bclk_prev_reg;
   assign lr_s      = lr_sync_reg[1];
   assign dat_s     = dat_sync_reg[1];

   // With the one-bit I2S delay, the rise that sees a new lrclk carries the old word's LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_reg     <= '0;
         bit_cnt_reg   <= '0;
         lr_prev_reg   <= CH_LEFT;
         word_reg      <= '0;
         word_done_reg <= 1'b0;
         word_good_reg <= 1'b0;
         word_ch_reg   <= CH_LEFT;
      end else begin
         word_done_reg <= 1'b0;
         if (bclk_rise) begin
            if (lr_s != lr_prev_reg) begin
               word_reg      <= {shreg_reg, dat_s};
               word_done_reg <= 1'b1;
               word_good_reg <= (bit_cnt_reg == CNT_LAST);
               word_ch_reg   <= lr_prev_reg;
               bit_cnt_reg   <= '0;
               lr_prev_reg   <= lr_s;
            end else begin
               shreg_reg <= {shreg_reg[DATA_W-3:0], dat_s};
               if (bit_cnt_reg != CNT_SAT) begin
                  bit_cnt_reg <= bit_cnt_reg + CW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= WAIT_SYNC;
         left_hold_reg <= '0;
         left_ok_reg   <= 1'b0;
         push_reg      <= 1'b0;
         push_data_reg <= '0;
         sync_err_reg  <= 1'b0;
      end else begin
         push_reg     <= 1'b0;
         sync_err_reg <= 1'b0;
         if (word_done_reg) begin
            case (state_reg)
               WAIT_SYNC: state_reg <= CAPTURE;
               CAPTURE: begin
                  if (!word_good_reg) begin
                     sync_err_reg <= 1'b1;
                     left_ok_reg  <= 1'b0;
                  end else if (word_ch_reg == CH_LEFT) begin
                     left_hold_reg <= word_reg;
                     left_ok_reg   <= 1'b1;
                  end else if (word_ch_reg == CH_RIGHT && left_ok_reg) begin
                     push_reg      <= 1'b1;
                     push_data_reg <= {left_hold_reg, word_reg};
                     left_ok_reg   <= 1'b0;
                  end
               end
               default: state_reg <= WAIT_SYNC;
            endcase
         end
      end
   end

   i2s_rx_fifo #(
      .WIDTH (2 * DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_reg),
      .wr_data (push_data_reg),
      .rd_en   (pop),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_valid              = !fifo_empty;
   assign pop                    = out_valid && out_ready;
   assign {out_left, out_right}  = fifo_head;

   // A fresh drop wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg <= 1'b0;
      end else if (push_reg && fifo_full && !pop) begin
         overflow_reg <= 1'b1;
      end else if (overflow_clr) begin
         overflow_reg <= 1'b0;
      end
   end

   assign overflow = overflow_reg;
   assign sync_err = sync_err_reg;

`ifdef I2S_RX_PEAK_EN
   function automatic logic [DATA_W-2:0] abs_sat(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] neg;
      neg = -v;
      if (!v[DATA_W-1]) begin
         return v[DATA_W-2:0];
      end
      if (neg[DATA_W-1]) begin
         return '1;
      end
      return neg[DATA_W-2:0];
   endfunction

   logic                   push_accept;
   logic [1:0][DATA_W-1:0] peak_src;
   logic [1:0][DATA_W-2:0] peak_all;

   assign push_accept        = push_reg && (!fifo_full || pop);
   assign peak_src[CH_LEFT]  = push_data_reg[2*DATA_W-1:DATA_W];
   assign peak_src[CH_RIGHT] = push_data_reg[DATA_W-1:0];

   for (genvar gi = 0; gi < 2; gi++) begin : g_peak
      logic [DATA_W-2:0] peak_reg;
      logic [DATA_W-2:0] mag;

      assign mag = abs_sat(peak_src[gi]);

      // A clear coinciding with a push restarts the meter from that pair.
      always_ff @(posedge clk) begin
         if (rst) begin
            peak_reg <= '0;
         end else if (push_accept) begin
            if (peak_clr || mag > peak_reg) begin
               peak_reg <= mag;
            end
         end else if (peak_clr) begin
            peak_reg <= '0;
         end
      end

      assign peak_all[gi] = peak_reg;
   end

   assign peak_l = peak_all[CH_LEFT];
   assign peak_r = peak_all[CH_RIGHT];
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Scoreboard bench for i2s_adc_rx: directed frames, queued expected pairs, negedge monitor.
module tb_i2s_adc_rx;

   localparam int DW = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bclk = 1'b0;
   logic lrclk = 1'b0;
   logic adcdat = 1'b0;
   logic out_ready = 1'b0;
   logic overflow_clr = 1'b0;
   logic [DW-1:0] out_left;
   logic [DW-1:0] out_right;
   logic out_valid;
   logic overflow;
   logic sync_err;
`ifdef I2S_RX_PEAK_EN
   logic [DW-2:0] peak_l;
   logic [DW-2:0] peak_r;
   logic peak_clr = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int sync_cnt = 0;
   int first_rise_cyc = 0;
   int n = 0;
   int s0 = 0;
   logic prev_lsb = 1'b0;
   logic [2*DW-1:0] exp_q[$];
   logic [2*DW-1:0] exp_pair;

   i2s_adc_rx dut (
      .clk          (clk),
      .rst          (rst),
      .i2s_bclk     (bclk),
      .i2s_lrclk    (lrclk),
      .i2s_adcdat   (adcdat),
      .out_left     (out_left),
      .out_right    (out_right),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .sync_err     (sync_err)
`ifdef I2S_RX_PEAK_EN
      ,
      .peak_l       (peak_l),
      .peak_r       (peak_r),
      .peak_clr     (peak_clr)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every accepted pair is compared against the head of the expected queue.
   always @(negedge clk) begin
      if (sync_err) sync_cnt++;
      if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pair_unexpected got L=%h R=%h required=no pair", out_left, out_right);
         end else begin
            exp_pair = exp_q.pop_front();
            if ({out_left, out_right} !== exp_pair) begin
               failures++;
               $display("FAIL pair got L=%h R=%h required L=%h R=%h",
                        out_left, out_right, exp_pair[2*DW-1:DW], exp_pair[DW-1:0]);
            end else begin
               $display("pair L=%h R=%h ok", out_left, out_right);
            end
         end
      end
   end

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end else begin
         $display("check %s = %h ok", name, got);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 out_ready = v;
   endtask

   // One slot: first bit is the previous word's LSB, then MSB downward.
   task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int len);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         bclk  = 1'b0;
         lrclk = lr;
         if (i == 0) adcdat = prev_lsb;
         else        adcdat = w[DW-i];
         repeat (16) @(negedge clk);
         bclk = 1'b1;
         if (i == 0) first_rise_cyc = cyc + 1;
         repeat (15) @(negedge clk);
      end
      prev_lsb = w[0];
   endtask

   task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit expect_pair);
      send_slot(1'b0, l, DW);
      send_slot(1'b1, r, DW);
      if (expect_pair) exp_q.push_back({l, r});
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got=%0d pending required=0", name, exp_q.size());
      end
   endtask

   initial begin
      #(10 * 150000);
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_valid", DW'(out_valid), 0);
      check("rst_left", out_left, 0);
      check("rst_right", out_right, 0);
      check("rst_overflow", DW'(overflow), 0);
      check("rst_sync_err", DW'(sync_err), 0);
`ifdef I2S_RX_PEAK_EN
      check("rst_peak_l", DW'(peak_l), 0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;

      // 1: first pair dropped, following pairs intact
      send_frame(24'hABCDEF, 24'h123456, 1'b0);
      send_frame(24'hABCDEF, 24'h123456, 1'b1);
      send_frame(24'hABCDEF, 24'h123456, 1'b1);
      send_slot(1'b0, 24'h000000, DW);
      wait_drain("t1");

      // 2: backpressure fills FIFO and overflows
      do_reset();
      set_ready(1'b0);
      for (int k = 1; k <= 6; k++) begin
         send_frame(24'(k * 24'h111111), 24'hA00000 + 24'(k), (k >= 2 && k <= 5));
      end
      send_slot(1'b0, 24'h000000, DW);
      repeat (10) @(negedge clk);
      check("t2_overflow", DW'(overflow), 1);
      check("t2_valid_held", DW'(out_valid), 1);
      check("t2_head_left", out_left, 24'h222222);
      check("t2_head_right", out_right, 24'hA00002);
      set_ready(1'b1);
      wait_drain("t2");
      @(negedge clk);
      check("t2_overflow_sticky", DW'(overflow), 1);
      @(posedge clk);
      #1 overflow_clr = 1'b1;
      @(posedge clk);
      #1 overflow_clr = 1'b0;
      @(negedge clk);
      check("t2_overflow_clr", DW'(overflow), 0);

      // 3: short left slot
      do_reset();
      s0 = sync_cnt;
      send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0);
      send_frame(24'h654321, 24'hFEDCBA, 1'b1);
      send_slot(1'b0, 24'h777777, 20);
      send_slot(1'b1, 24'h888888, DW);
      send_frame(24'h0000FF, 24'hFF0000, 1'b1);
      send_slot(1'b0, 24'h000000, DW);
      wait_drain("t3");
      check("t3_sync_err_count", DW'(sync_cnt - s0), 1);

      // 4: reset in the middle of a right slot
      do_reset();
      set_ready(1'b0);
      send_frame(24'h111000, 24'h000111, 1'b0);
      send_frame(24'h2468AC, 24'h13579B, 1'b1);
      send_slot(1'b0, 24'h555555, DW);
      repeat (10) @(negedge clk);
      check("t4_valid_before_rst", DW'(out_valid), 1);
      fork
         send_slot(1'b1, 24'hAAAAAA, DW);
         begin
            repeat (10 * 32 + 8) @(negedge clk);
            @(posedge clk);
            #1 rst = 1'b1;
            exp_q.delete();
            @(posedge clk);
            @(negedge clk);
            check("t4_valid_after_rst", DW'(out_valid), 0);
            check("t4_left_after_rst", out_left, 0);
            @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      set_ready(1'b1);
      send_frame(24'h3C3C3C, 24'hC3C3C3, 1'b1);
      send_frame(24'h010203, 24'h040506, 1'b1);
      send_slot(1'b0, 24'h000000, DW);
      wait_drain("t4");

      // 5: extreme values and latency
      do_reset();
      send_frame(24'h000001, 24'h000002, 1'b0);
      send_frame(24'h800000, 24'h7FFFFF, 1'b1);
      fork
         send_slot(1'b0, 24'h000000, DW);
         begin
            n = 0;
            while (!out_valid && n < 2000) begin
               @(negedge clk);
               n++;
            end
            check("t5_latency", DW'(cyc - first_rise_cyc), 4);
            @(negedge clk);
            check("t5_no_stall", DW'(out_valid), 0);
         end
      join
      wait_drain("t5");

`ifdef I2S_RX_PEAK_EN
      // 6: peak meters
      do_reset();
      send_frame(24'h000000, 24'h000000, 1'b0);
      send_frame(24'hFFFFFB, 24'h000003, 1'b1);
      send_frame(24'h000002, 24'hFFFFF7, 1'b1);
      send_slot(1'b0, 24'h800000, DW);
      wait_drain("t6a");
      repeat (4) @(negedge clk);
      check("t6_peak_l", DW'(peak_l), 5);
      check("t6_peak_r", DW'(peak_r), 9);
      @(posedge clk);
      #1 peak_clr = 1'b1;
      @(posedge clk);
      #1 peak_clr = 1'b0;
      @(negedge clk);
      check("t6_peak_l_clr", DW'(peak_l), 0);
      check("t6_peak_r_clr", DW'(peak_r), 0);
      send_slot(1'b1, 24'h000000, DW);
      exp_q.push_back({24'h800000, 24'h000000});
      send_slot(1'b0, 24'h000000, DW);
      wait_drain("t6b");
      repeat (4) @(negedge clk);
      check("t6_peak_l_sat", DW'(peak_l), 24'h7FFFFF);
      check("t6_peak_r_zero", DW'(peak_r), 0);
`endif

      repeat (10) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
